// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
//   op_e    : shift mode encoding driven on the op port (5..7 reserved = hold)
//   state_e : burst FSM states
package usr_pkg;

  typedef enum logic [2:0] {
    OP_SHL = 3'd0,
    OP_SHR = 3'd1,
    OP_ROL = 3'd2,
    OP_ROR = 3'd3,
    OP_ASR = 3'd4
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational shift/rotate datapath shared by the single-step and burst paths.
// Ports:
//   q        in  WIDTH  current register contents
//   op       in  3      shift mode (usr_pkg::op_e values; 5..7 reserved)
//   ser_in   in  1      serial fill bit for SHL/SHR
//   next_q   out WIDTH  register contents after one shift
//   next_out out 1      bit shifted/rotated out by this shift
//   op_valid out 1      low for reserved modes; caller then holds q and ser_out
module usr_shift_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_q,
  output logic             next_out,
  output logic             op_valid
);

  always_comb begin
    next_q   = q;
    next_out = 1'b0;
    op_valid = 1'b1;
    case (op)
      OP_SHL: begin
        next_q   = {q[WIDTH-2:0], ser_in};
        next_out = q[WIDTH-1];
      end
      OP_SHR: begin
        next_q   = {ser_in, q[WIDTH-1:1]};
        next_out = q[0];
      end
      OP_ROL: begin
        next_q   = {q[WIDTH-2:0], q[WIDTH-1]};
        next_out = q[WIDTH-1];
      end
      OP_ROR: begin
        next_q   = {q[0], q[WIDTH-1:1]};
        next_out = q[0];
      end
      OP_ASR: begin
        next_q   = {q[WIDTH-1], q[WIDTH-1:1]};
        next_out = q[0];
      end
      default: begin
        op_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with parallel load, single-step shifts
// and an autonomous burst of `count` shifts launched by one start strobe.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   load_en, d_load parallel load (highest priority, aborts a burst)
//   shift_en        single shift using live op (IDLE only)
//   op              shift mode, see usr_pkg::op_e
//   start, count    burst launch and shift count (IDLE only)
//   ser_in          serial fill bit, sampled on every shift edge
//   q               register contents
//   ser_out         last bit shifted/rotated out (registered)
//   busy            burst in progress
//   done            one-cycle pulse after a burst completes (or count=0 start)
//
// state    | meaning
// ST_IDLE  | waiting; accepts load_en > start > shift_en
// ST_SHIFT | burst running, one shift per edge with latched op_q until rem hits 1
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d_load,
  input  logic             shift_en,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic [CNT_W-1:0] rem;
  logic [2:0]       op_q;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] next_q;
  logic             next_out;
  logic             op_valid;

  // Live op steers single steps; a running burst ignores op changes.
  assign op_sel = (state == ST_SHIFT) ? op_q : op;

  usr_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .q       (q),
    .op      (op_sel),
    .ser_in  (ser_in),
    .next_q  (next_q),
    .next_out(next_out),
    .op_valid(op_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      q       <= '0;
      ser_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rem     <= '0;
      op_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_en) begin
            q <= d_load;
          end else if (start) begin
            if (count != '0) begin
              op_q  <= op;
              rem   <= count;
              busy  <= 1'b1;
              state <= ST_SHIFT;
            end else begin
              done <= 1'b1;
            end
          end else if (shift_en && op_valid) begin
            q       <= next_q;
            ser_out <= next_out;
          end
        end
        ST_SHIFT: begin
          if (load_en) begin
            // abort: no done pulse
            q     <= d_load;
            rem   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            // reserved op_q holds data but the burst still counts down
            if (op_valid) begin
              q       <= next_q;
              ser_out <= next_out;
            end
            rem <= rem - 1'b1;
            if (rem == CNT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register: generalises our fixed 4-bit load/shift flop into a WIDTH-bit register. It supports parallel load, five shift/rotate modes, serial in/out, and an autonomous burst mode that performs N shifts from a single start strobe. It sits between the datapath and serial peripherals as a serializer/deserializer and bit-manipulation stage.

## Interface
Parameters:
- WIDTH, 8: register width in bits (≥2).
- CNT_W, 8: width of burst shift count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  parallel load strobe.
- d_load  in  WIDTH  parallel load data.
- shift_en  in  1  single-step shift strobe (IDLE only).
- op  in  3  shift mode (see Operation).
- start  in  1  burst start strobe (IDLE only).
- count  in  CNT_W  number of shifts in a burst.
- ser_in  in  1  serial fill bit, sampled on every shift edge.
- q  out  WIDTH  register contents.
- ser_out  out  1  registered bit most recently shifted/rotated out.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse after a burst completes.

## Operation
- op encoding:
  - 0 SHL: q←{q[W-2:0],ser_in}, out=q[W-1].
  - 1 SHR: q←{ser_in,q[W-1:1]}, out=q[0].
  - 2 ROL: q←{q[W-2:0],q[W-1]}, out=q[W-1].
  - 3 ROR: q←{q[0],q[W-1:1]}, out=q[0].
  - 4 ASR: q←{q[W-1],q[W-1:1]}, out=q[0].
  - 5–7: reserved, treated as hold; q and ser_out unchanged.
- FSM states:
  - IDLE:
    - Priority load_en > start > shift_en > hold.
    - load_en: q←d_load; ser_out unchanged.
    - start with count≠0: latch op→op_q and count→rem; go to SHIFT.
    - start with count=0: stay IDLE and pulse done next cycle; no shift.
    - shift_en: one shift using the live op.
  - SHIFT:
    - Each edge performs one shift with op_q; rem decrements.
    - On the edge where rem==1: shift, go to IDLE, set done=1 for one cycle.
    - start, shift_en and op are ignored.
    - load_en aborts the burst: q←d_load, go to IDLE, no done pulse.
- Simultaneous load_en+start in IDLE: load wins, start is dropped.
- Reset, including mid-burst: q=0, ser_out=0, busy=0, done=0, state IDLE, rem=0, op_q=0.
- A burst may be longer than WIDTH; it simply keeps shifting, up to 2^CNT_W−1 shifts.

## Timing
- Load and single-step shift: q updates on the sampling edge (1-cycle latency).
- Burst: start sampled at edge 0; shifts occur on edges 1..N.
  - busy=1 after edge 0 through edge N; busy falls after edge N.
  - done=1 for exactly the cycle after edge N.
- count=0: done is high for the cycle after edge 0; busy never asserts.
- A new start is accepted in the same cycle done is high, since the state is IDLE.
- All outputs are registered; none is combinational from inputs.

## Structure
- Package usr_pkg holds:
  - typedef enum logic [2:0] op_e {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR}.
  - typedef enum logic state_e {ST_IDLE, ST_SHIFT}.
- One combinational sub-module, usr_shift_unit (WIDTH): given q, op and ser_in, computes next_q and next_out. It is shared by single-step and burst paths.
- The top level holds the FSM, rem counter, op_q, and the output registers.

## Test plan
- Reset/load: assert rst mid-run → q=0, ser_out=0, busy=0, done=0. Release, then load_en with d_load=8'hA5 → q=8'hA5.
- Single-step modes: q=8'h81, op=ASR, shift_en → q=8'hC0, ser_out=1. Then ROL → q=8'h81, ser_out=1. Then SHL with ser_in=0 → q=8'h02.
- Burst serialization: q=8'hB4, op=SHR, count=8, start, ser_in=0. ser_out sequence is 0,0,1,0,1,1,0,1 on edges 1–8; busy stays high 8 cycles; done pulses once; final q=8'h00.
- count=0 and long burst:
  - count=0 start → done pulse with q unchanged, busy=0.
  - count=12, ROR on 8'h01 → q=8'h10 after 12 shifts.
- Abort and priority:
  - load_en at burst edge 3 → q=d_load, busy=0, no done.
  - Simultaneous load_en+start in IDLE → load only, busy stays 0.
- Ignored inputs and reserved op:
  - shift_en/start/op changes during SHIFT have no effect on the burst.
  - op=6 with shift_en → q unchanged.
